mem_req_ctrl: RTL

//  Memory-stage data-access controller at the consumer end of the EX/MEM latch. Converts

---
 rtl/cpu_types_pkg.sv | 42 ++++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_req_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, memory-controller FSM states, func3 encodings and size helpers.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, MISAL} memctl_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  typedef struct packed {
    logic [2:0] func3;
    logic [1:0] off;
    logic       wr;
  } mem_req_t;

  // Unlisted func3 encodings fall through to word size.
  function automatic mem_size_t size_of(input logic [2:0] f3);
    case (f3)
      LB, LBU: size_of = SZ_B;
      LH, LHU: size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (size_of(f3))
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge into a read word.
module mem_lane_align
  import cpu_types_pkg::*;
(
  input  word_t       rdata,
  input  word_t       wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output word_t       load_ext,
  output word_t       merged
);
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_l, wr_l, mg_l;
  mem_size_t   sz;
  logic        sgn;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign rd_l   = rdata;
  assign wr_l   = wdata;
  assign sz     = size_of(func3);
  assign sgn    = ~func3[2];
  assign byte_v = rd_l[off];
  assign half_v = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (sz)
      SZ_B:    load_ext = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    load_ext = {{16{sgn & half_v[15]}}, half_v};
      default: load_ext = rdata;
    endcase
  end

  // Sub-word store data sits in the low lanes of rs2 and is steered to the addressed lanes.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] K  = 2'(k);
    localparam int         HK = k % 2;
    logic hit;
    always_comb begin
      case (sz)
        SZ_B:    hit = (off == K);
        SZ_H:    hit = (off[1] == K[1]);
        default: hit = 1'b1;
      endcase
    end
    assign mg_l[k] = !hit        ? rd_l[k] :
                     (sz == SZ_B) ? wr_l[0] :
                     (sz == SZ_H) ? wr_l[HK] : wr_l[k];
  end

  assign merged = mg_l;
endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage dcache request controller: word-aligned requests, RMW sub-word stores, load extend.
// Optional LR/SC reservation support is built when MEM_ATOMIC_EN is defined.
module mem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_i,
  input  logic [2:0]  func3_i,
  input  logic        atomic_i,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        dhit_o,
  output logic        busy_o,
  output logic [31:0] load_o,
  output logic        misalign_o,
  output logic        timeout_o
);
  memctl_state_t        state, state_n;
  mem_req_t             req_q;
  logic                 hold_q, scfail_q;
  logic [TIMEOUT_W-1:0] wait_cnt;
  word_t                ext_w, merged_w;
  logic                 req_v, mis_w, sc_fail_w;
  mem_size_t            sz_i;

  // dmemstore holds rs2 during RMW_RD, so it doubles as the merge source.
  mem_lane_align u_align (
    .rdata    (dmemload),
    .wdata    (dmemstore),
    .off      (req_q.off),
    .func3    (req_q.func3),
    .load_ext (ext_w),
    .merged   (merged_w)
  );

  // The latch drops its request on the edge after dhit_o, so that cycle is ignored.
  assign req_v  = (dREN_i | dWEN_i) & ~hold_q;
  assign mis_w  = misaligned(func3_i, addr_i[1:0]);
  assign sz_i   = size_of(func3_i);
  assign busy_o = (dREN_i | dWEN_i) & ~dhit_o;

`ifdef MEM_ATOMIC_EN
  logic        resv_v, lr_q, resv_hit;
  logic [29:0] resv_a;

  assign resv_hit  = resv_v & (resv_a == addr_i[31:2]);
  assign sc_fail_w = dWEN_i & atomic_i & ~resv_hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resv_v <= 1'b0;
      resv_a <= '0;
      lr_q   <= 1'b0;
    end else if (state == IDLE && req_v) begin
      lr_q <= ~dWEN_i & atomic_i;
      if (dWEN_i & (atomic_i | resv_hit)) resv_v <= 1'b0;
    end else if (state == ACCESS && dhit && lr_q) begin
      resv_v <= 1'b1;
      resv_a <= dmemaddr[31:2];
    end
  end
`else
  logic unused_atomic;
  assign unused_atomic = atomic_i;
  assign sc_fail_w     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dhit_o     = 1'b0;
    misalign_o = 1'b0;
    load_o     = '0;
    case (state)
      IDLE: begin
        if (req_v) begin
          if (mis_w || sc_fail_w)            state_n = MISAL;
          else if (!dWEN_i || sz_i == SZ_W)  state_n = ACCESS;
          else                               state_n = RMW_RD;
        end
      end
      ACCESS: begin
        dmemREN = ~req_q.wr;
        dmemWEN = req_q.wr;
        if (dhit) begin
          dhit_o  = 1'b1;
          state_n = IDLE;
          if (!req_q.wr) load_o = ext_w;
        end
      end
      RMW_RD: begin
        dmemREN = 1'b1;
        if (dhit) state_n = RMW_WR;
      end
      RMW_WR: begin
        dmemWEN = 1'b1;
        if (dhit) begin
          dhit_o  = 1'b1;
          state_n = IDLE;
        end
      end
      MISAL: begin
        // Shared by misaligned drops and failed SC; only the latter reports load_o=1.
        dhit_o     = 1'b1;
        misalign_o = ~scfail_q;
        load_o     = {31'b0, scfail_q};
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_q     <= '0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      hold_q    <= 1'b0;
      scfail_q  <= 1'b0;
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      hold_q <= dhit_o;
      if (state == IDLE && req_v) begin
        req_q     <= '{func3: func3_i, off: addr_i[1:0], wr: dWEN_i};
        dmemaddr  <= {addr_i[31:2], 2'b00};
        dmemstore <= store_i;
        scfail_q  <= ~mis_w & sc_fail_w;
      end else if (state == RMW_RD && dhit) begin
        dmemstore <= merged_w;
      end
      if (state inside {ACCESS, RMW_RD, RMW_WR}) begin
        if (dhit)                 wait_cnt <= '0;
        else if (wait_cnt != '1)  wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        if (&wait_cnt)            timeout_o <= 1'b1;
      end
    end
  end
endmodule
